operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 244 ++++++++++++++++++++++++
 tb/tb_operand_fetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// operand_fetch: reads 0..3 little-endian operand bytes starting at pc,
// optionally follows a pointer for the indirect modes, and produces the
// effective address.
// One byte read takes two cycles: a read cycle (mem_read, mem_address)
// and a wait cycle in which the byte returned on mem_data_in is captured.
// Build option: define LONG_POINTER_EN to fetch 3-byte (24-bit) pointers;
// otherwise pointers are 2 bytes and pointer[23:16] stays zero.
// Mode encoding (shared MODE_* constants):
//   0 NONE, 1 A, 2 IMMEDIATE, 3 ZP, 4 ABSOLUTE, 5 INDEXED_X, 6 ABSOLUTE_X,
//   7 ABSOLUTE_Y, 8 STACK_RELATIVE, 9 INDIRECT_X, 10 INDIRECT_Y,
//   11 STACK_INDIRECT_Y; codes 12..15 are unlisted (ea = 0).
module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mode,
  input  logic [2:0]  extra_bytes,
  input  logic [23:0] pc,
  input  logic [31:0] reg_x,
  input  logic [31:0] reg_y,
  input  logic [31:0] reg_sp,
  output logic [23:0] mem_address,
  output logic        mem_read,
  input  logic [7:0]  mem_data_in,
  output logic        busy,
  output logic        done,
  output logic [23:0] operand,
  output logic [23:0] ea,
  output logic [23:0] pc_next
);

  localparam logic [3:0] MODE_NONE             = 4'd0;
  localparam logic [3:0] MODE_A                = 4'd1;
  localparam logic [3:0] MODE_IMMEDIATE        = 4'd2;
  localparam logic [3:0] MODE_ZP               = 4'd3;
  localparam logic [3:0] MODE_ABSOLUTE         = 4'd4;
  localparam logic [3:0] MODE_INDEXED_X        = 4'd5;
  localparam logic [3:0] MODE_ABSOLUTE_X       = 4'd6;
  localparam logic [3:0] MODE_ABSOLUTE_Y       = 4'd7;
  localparam logic [3:0] MODE_STACK_RELATIVE   = 4'd8;
  localparam logic [3:0] MODE_INDIRECT_X       = 4'd9;
  localparam logic [3:0] MODE_INDIRECT_Y       = 4'd10;
  localparam logic [3:0] MODE_STACK_INDIRECT_Y = 4'd11;

`ifdef LONG_POINTER_EN
  localparam logic [1:0] PTR_BYTES = 2'd3;
`else
  localparam logic [1:0] PTR_BYTES = 2'd2;
`endif

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_OP_READ  = 3'd1;
  localparam logic [2:0] S_OP_WAIT  = 3'd2;
  localparam logic [2:0] S_PTR_READ = 3'd3;
  localparam logic [2:0] S_PTR_WAIT = 3'd4;
  localparam logic [2:0] S_COMPUTE  = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [1:0]  idx;
  logic [1:0]  n_r;
  logic [1:0]  n_in;
  logic [3:0]  mode_r;
  logic [23:0] pc_r;
  logic [23:0] x_r;
  logic [23:0] y_r;
  logic [23:0] sp_r;
  logic [23:0] ptr_r;
  logic [23:0] base_r;
  logic [23:0] operand_upd;
  logic [23:0] ptr_upd;
  logic [23:0] base_calc;
  logic [23:0] ea_calc;
  logic [23:0] addr_next;
  logic        read_next;
  logic        unused_bits;

  // Only the low 24 bits of the index/stack registers take part in addressing.
  assign unused_bits = ^{reg_x[31:24], reg_y[31:24], reg_sp[31:24]};

  function automatic logic is_indirect(input logic [3:0] m);
    case (m)
      MODE_INDIRECT_X, MODE_INDIRECT_Y, MODE_STACK_INDIRECT_Y: is_indirect = 1'b1;
      default:                                                 is_indirect = 1'b0;
    endcase
  endfunction

  // Replace byte i of a 24-bit little-endian word.
  function automatic logic [23:0] put_byte(input logic [23:0] w, input logic [1:0] i,
                                           input logic [7:0] b);
    put_byte = w;
    case (i)
      2'd0:    put_byte[7:0]   = b;
      2'd1:    put_byte[15:8]  = b;
      2'd2:    put_byte[23:16] = b;
      default: put_byte        = w;
    endcase
  endfunction

  // Byte count clamp plus the operand/pointer words including the byte arriving now.
  always_comb begin
    n_in        = (extra_bytes > 3'd3) ? 2'd3 : extra_bytes[1:0];
    operand_upd = put_byte(operand, idx, mem_data_in);
    ptr_upd     = put_byte(ptr_r, idx, mem_data_in);
  end

  // Pointer base, formed from the complete operand as its last byte lands.
  always_comb begin
    case (mode_r)
      MODE_INDIRECT_X:       base_calc = operand_upd + x_r;
      MODE_STACK_INDIRECT_Y: base_calc = sp_r + operand_upd;
      default:               base_calc = operand_upd;
    endcase
  end

  // Effective address from the latched mode, registers, operand and pointer.
  always_comb begin
    case (mode_r)
      MODE_IMMEDIATE:                         ea_calc = pc_r;
      MODE_ZP, MODE_ABSOLUTE:                 ea_calc = operand;
      MODE_INDEXED_X, MODE_ABSOLUTE_X:        ea_calc = operand + x_r;
      MODE_ABSOLUTE_Y:                        ea_calc = operand + y_r;
      MODE_STACK_RELATIVE:                    ea_calc = sp_r + operand;
      MODE_INDIRECT_X:                        ea_calc = ptr_r;
      MODE_INDIRECT_Y, MODE_STACK_INDIRECT_Y: ea_calc = ptr_r + y_r;
      MODE_NONE, MODE_A:                      ea_calc = 24'd0;
      default:                                ea_calc = 24'd0;
    endcase
  end

  // Next state and the address to present when the next state is a read state.
  always_comb begin
    state_next = state;
    addr_next  = 24'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (n_in != 2'd0) begin
            state_next = S_OP_READ;
            addr_next  = pc;
          end else begin
            state_next = S_COMPUTE;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_OP_READ: state_next = S_OP_WAIT;
      S_OP_WAIT: begin
        if (idx == (n_r - 2'd1)) begin
          if (is_indirect(mode_r)) begin
            state_next = S_PTR_READ;
            addr_next  = base_calc;
          end else begin
            state_next = S_COMPUTE;
          end
        end else begin
          state_next = S_OP_READ;
          addr_next  = pc_r + {22'd0, idx} + 24'd1;
        end
      end
      S_PTR_READ: state_next = S_PTR_WAIT;
      S_PTR_WAIT: begin
        if (idx == (PTR_BYTES - 2'd1)) begin
          state_next = S_COMPUTE;
        end else begin
          state_next = S_PTR_READ;
          addr_next  = base_r + {22'd0, idx} + 24'd1;
        end
      end
      S_COMPUTE: state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
    read_next = (state_next == S_OP_READ) || (state_next == S_PTR_READ);
  end

  // State, registered outputs and per-request working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= 2'd0;
      n_r         <= 2'd0;
      mode_r      <= 4'd0;
      pc_r        <= 24'd0;
      x_r         <= 24'd0;
      y_r         <= 24'd0;
      sp_r        <= 24'd0;
      ptr_r       <= 24'd0;
      base_r      <= 24'd0;
      mem_read    <= 1'b0;
      mem_address <= 24'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      operand     <= 24'd0;
      ea          <= 24'd0;
      pc_next     <= 24'd0;
    end else begin
      state       <= state_next;
      mem_read    <= read_next;
      mem_address <= read_next ? addr_next : 24'd0;
      busy        <= (state_next != S_IDLE) && (state_next != S_DONE);
      done        <= (state_next == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r  <= mode;
            n_r     <= n_in;
            pc_r    <= pc;
            x_r     <= reg_x[23:0];
            y_r     <= reg_y[23:0];
            sp_r    <= reg_sp[23:0];
            idx     <= 2'd0;
            operand <= 24'd0;
            ptr_r   <= 24'd0;
            base_r  <= 24'd0;
          end
        end
        S_OP_WAIT: begin
          operand <= operand_upd;
          if (idx == (n_r - 2'd1)) begin
            idx    <= 2'd0;
            base_r <= base_calc;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        S_PTR_WAIT: begin
          ptr_r <= ptr_upd;
          idx   <= idx + 2'd1;
        end
        S_COMPUTE: begin
          ea      <= ea_calc;
          pc_next <= pc_r + {22'd0, n_r};
        end
        default: begin
          idx <= idx;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: a behavioural model lists the
// expected byte reads, latency and results of each request, and one
// compare process checks the outputs on every falling edge.
module tb_operand_fetch;

  localparam logic [3:0] M_NONE = 4'd0,  M_IMM = 4'd2,  M_ZP = 4'd3,  M_ABS = 4'd4;
  localparam logic [3:0] M_IDX = 4'd5,   M_ABX = 4'd6,  M_ABY = 4'd7, M_SR = 4'd8;
  localparam logic [3:0] M_IX = 4'd9,    M_IY = 4'd10,  M_SIY = 4'd11;
`ifdef LONG_POINTER_EN
  localparam int PW = 3;
  localparam logic [23:0] EA_IY_PIN = 24'h018005;
  localparam int LAT_IY_PIN = 10;
`else
  localparam int PW = 2;
  localparam logic [23:0] EA_IY_PIN = 24'h008005;
  localparam int LAT_IY_PIN = 8;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  mode;
  logic [2:0]  extra_bytes;
  logic [23:0] pc;
  logic [31:0] reg_x, reg_y, reg_sp;
  logic [23:0] mem_address;
  logic        mem_read;
  logic [7:0]  mem_data_in;
  logic        busy, done;
  logic [23:0] operand, ea, pc_next;

  operand_fetch dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .extra_bytes(extra_bytes),
    .pc(pc), .reg_x(reg_x), .reg_y(reg_y), .reg_sp(reg_sp),
    .mem_address(mem_address), .mem_read(mem_read), .mem_data_in(mem_data_in),
    .busy(busy), .done(done), .operand(operand), .ea(ea), .pc_next(pc_next)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0]  mem_ovr [int];
  logic [23:0] exp_addr [$];
  logic [23:0] exp_op, exp_ea, exp_pcn;
  logic [23:0] held_op, held_ea, held_pcn;
  int exp_cyc;
  int k;
  int done_k;
  bit act = 1'b0;
  bit txn_done = 1'b0;
  bit chk_idle = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ a[23:16] ^ 8'h3C;
  endfunction

  function automatic bit is_ind(input logic [3:0] m);
    return (m == M_IX) || (m == M_IY) || (m == M_SIY);
  endfunction

  // Model: which bytes are read, what they assemble to, and the resulting ea.
  function automatic void build_model(input logic [3:0] m, input logic [2:0] eb,
                                      input logic [23:0] pcv, input logic [31:0] xv,
                                      input logic [31:0] yv, input logic [31:0] spv);
    int n, p;
    logic [23:0] op, ptr, base, a, x, y, sp;
    x = xv[23:0]; y = yv[23:0]; sp = spv[23:0];
    n = (eb > 3'd3) ? 3 : int'(eb);
    p = 0; op = 24'd0; ptr = 24'd0;
    exp_addr.delete();
    for (int i = 0; i < n; i++) begin
      a = pcv + 24'(i);
      exp_addr.push_back(a);
      op = op | (24'(mem_byte(a)) << (8 * i));
    end
    if (n > 0 && is_ind(m)) begin
      p = PW;
      base = (m == M_IX) ? op + x : (m == M_SIY) ? sp + op : op;
      for (int i = 0; i < p; i++) begin
        a = base + 24'(i);
        exp_addr.push_back(a);
        ptr = ptr | (24'(mem_byte(a)) << (8 * i));
      end
    end
    case (m)
      M_IMM:        exp_ea = pcv;
      M_ZP, M_ABS:  exp_ea = op;
      M_IDX, M_ABX: exp_ea = op + x;
      M_ABY:        exp_ea = op + y;
      M_SR:         exp_ea = sp + op;
      M_IX:         exp_ea = ptr;
      M_IY, M_SIY:  exp_ea = ptr + y;
      default:      exp_ea = 24'd0;
    endcase
    exp_op  = op;
    exp_pcn = pcv + 24'(n);
    exp_cyc = 2 * (n + p) + 2;
  endfunction

  // Memory: data for a read strobe returns one cycle later; junk otherwise.
  initial forever begin
    @(posedge clk);
    if (mem_read === 1'b1) mem_data_in <= mem_byte(mem_address);
    else                   mem_data_in <= 8'($urandom);
  end

  // Compare process: k counts falling edges since the accepting edge.
  initial forever begin
    bit exp_rd;
    @(negedge clk);
    if (act) begin
      k++;
      exp_rd = (k % 2 == 1) && (((k - 1) / 2) < exp_addr.size());
      chk("mem_read", {31'd0, mem_read}, {31'd0, exp_rd});
      if (exp_rd) chk("mem_address", {8'd0, mem_address}, {8'd0, exp_addr[(k - 1) / 2]});
      chk("busy", {31'd0, busy}, {31'd0, k < exp_cyc});
      chk("done", {31'd0, done}, {31'd0, k == exp_cyc});
      if (done === 1'b1) done_k = k;
      if (k >= exp_cyc) begin
        chk("operand", {8'd0, operand}, {8'd0, exp_op});
        chk("ea", {8'd0, ea}, {8'd0, exp_ea});
        chk("pc_next", {8'd0, pc_next}, {8'd0, exp_pcn});
        held_op = exp_op; held_ea = exp_ea; held_pcn = exp_pcn;
        act = 1'b0;
        txn_done = 1'b1;
      end
    end else if (chk_idle) begin
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_mem_read", {31'd0, mem_read}, 32'd0);
      chk("held_operand", {8'd0, operand}, {8'd0, held_op});
      chk("held_ea", {8'd0, ea}, {8'd0, held_ea});
      chk("held_pc_next", {8'd0, pc_next}, {8'd0, held_pcn});
    end
  end

  task automatic do_reset();
    act = 1'b0; chk_idle = 1'b0; start = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
    chk("rst_mem_address", {8'd0, mem_address}, 32'd0);
    chk("rst_operand", {8'd0, operand}, 32'd0);
    chk("rst_ea", {8'd0, ea}, 32'd0);
    chk("rst_pc_next", {8'd0, pc_next}, 32'd0);
    reset = 1'b0;
    held_op = 24'd0; held_ea = 24'd0; held_pcn = 24'd0;
    chk_idle = 1'b1;
  endtask

  // Issue one request from an IDLE cycle; hold keeps start high throughout.
  task automatic txn(input logic [3:0] m, input logic [2:0] eb, input logic [23:0] pcv,
                     input logic [31:0] xv, input logic [31:0] yv, input logic [31:0] spv,
                     input bit hold);
    mode = m; extra_bytes = eb; pc = pcv; reg_x = xv; reg_y = yv; reg_sp = spv;
    start = 1'b1;
    build_model(m, eb, pcv, xv, yv, spv);
    @(posedge clk);
    k = 0; done_k = -1; txn_done = 1'b0; act = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk); #1;
      if (txn_done) break;
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      mode = 4'($urandom); extra_bytes = 3'($urandom); pc = 24'($urandom);
      reg_x = $urandom; reg_y = $urandom; reg_sp = $urandom;
    end
    if (!txn_done) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: done not seen within 64 cycles (mode %0d)", m);
      act = 1'b0;
    end
    start = hold;
  endtask

  initial begin
    start = 1'b0; reset = 1'b1; mode = 4'd0; extra_bytes = 3'd0; pc = 24'd0;
    reg_x = 32'd0; reg_y = 32'd0; reg_sp = 32'd0;
    mem_ovr[32'h001000] = 8'h34; mem_ovr[32'h001001] = 8'h12;
    mem_ovr[32'h004000] = 8'h20;
    mem_ovr[32'h000020] = 8'h00; mem_ovr[32'h000021] = 8'h80; mem_ovr[32'h000022] = 8'h01;
    mem_ovr[32'hFFFFFF] = 8'hCD; mem_ovr[32'h000000] = 8'hAB;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Absolute,X with two operand bytes.
    txn(M_ABX, 3'd2, 24'h001000, 32'h10, 32'h0, 32'h0, 1'b0);
    chk("pin_absx_operand", {8'd0, operand}, 32'h001234);
    chk("pin_absx_ea", {8'd0, ea}, 32'h001244);
    chk("pin_absx_pc_next", {8'd0, pc_next}, 32'h001002);
    chk("pin_absx_latency", done_k, 6);

    // Indirect,Y through a zero-page pointer.
    txn(M_IY, 3'd1, 24'h004000, 32'h0, 32'h5, 32'h0, 1'b0);
    chk("pin_indy_ea", {8'd0, ea}, {8'd0, EA_IY_PIN});
    chk("pin_indy_latency", done_k, LAT_IY_PIN);

    // No operand bytes at all.
    txn(M_NONE, 3'd0, 24'h123456, 32'h77, 32'h88, 32'h99, 1'b0);
    chk("pin_none_ea", {8'd0, ea}, 32'h0);
    chk("pin_none_latency", done_k, 2);

    // Operand bytes straddle the top of the address space.
    txn(M_ABY, 3'd2, 24'hFFFFFF, 32'h0, 32'h1, 32'h0, 1'b0);
    chk("pin_wrap_operand", {8'd0, operand}, 32'h00ABCD);
    chk("pin_wrap_ea", {8'd0, ea}, 32'h00ABCE);
    chk("pin_wrap_pc_next", {8'd0, pc_next}, 32'h000001);

    // Clamped byte count: 7 behaves as 3.
    txn(M_ABS, 3'd7, 24'h000300, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("pin_clamp_pc_next", {8'd0, pc_next}, 32'h000303);

    // Reset during the second operand wait, then a normal request.
    mode = M_ABS; extra_bytes = 3'd3; pc = 24'h002000; start = 1'b1;
    @(posedge clk);
    start = 1'b0; chk_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    txn(M_ABX, 3'd2, 24'h001000, 32'h10, 32'h0, 32'h0, 1'b0);
    chk("pin_after_reset_ea", {8'd0, ea}, 32'h001244);

    // start held high across back-to-back requests.
    txn(M_SR, 3'd1, 24'h000500, 32'h0, 32'h0, 32'h1FF, 1'b1);
    txn(M_IX, 3'd1, 24'h000600, 32'h3, 32'h0, 32'h0, 1'b1);
    txn(M_SIY, 3'd2, 24'h000700, 32'h0, 32'h9, 32'h100, 1'b1);
    txn(M_IMM, 3'd3, 24'h000800, 32'h0, 32'h0, 32'h0, 1'b0);

    // Random requests.
    for (int i = 0; i < 80; i++) begin
      logic [3:0]  m;
      logic [2:0]  eb;
      logic [23:0] pv;
      m  = 4'($urandom_range(0, 15));
      eb = 3'($urandom_range(0, 7));
      if (is_ind(m) && eb == 3'd0) eb = 3'd1;
      pv = ($urandom_range(0, 3) == 0) ? (24'hFFFFFF - 24'($urandom_range(0, 2))) : 24'($urandom);
      txn(m, eb, pv, $urandom, $urandom, $urandom, (i < 79) && ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk_idle = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
